// File: rtl/pwm_multi_channel.sv
// NUM_CH edge-aligned PWM channels sharing one period counter; new config is
// accepted by valid/ready into shadow registers and applied on a period boundary.
module pwm_multi_channel #(
  parameter int NUM_CH       = 4,
  parameter int CNT_W        = 8,
  parameter int RESET_PERIOD = 3,
  parameter int RESET_DUTY   = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [CNT_W-1:0]        cfg_period,
  input  logic [NUM_CH*CNT_W-1:0] cfg_duty,
  input  logic [NUM_CH-1:0]       cfg_inv,
  output logic [NUM_CH-1:0]       pwm_out,
  output logic                    period_done
);

  localparam logic [CNT_W-1:0] RST_P = CNT_W'(RESET_PERIOD);
  localparam logic [CNT_W-1:0] RST_D = CNT_W'(RESET_DUTY);

  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        active_period;
  logic [NUM_CH*CNT_W-1:0] active_duty;
  logic [NUM_CH-1:0]       active_inv;
  logic [CNT_W-1:0]        shadow_period;
  logic [NUM_CH*CNT_W-1:0] shadow_duty;
  logic [NUM_CH-1:0]       shadow_inv;
  logic                    pending;

  logic                    at_end;
  logic                    xfer;
  logic                    apply;
  logic [NUM_CH-1:0]       level;

  always_comb begin
    level = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      level[i] = (cnt < active_duty[i*CNT_W +: CNT_W]) ^ active_inv[i];
    end
  end

  assign at_end    = (cnt == active_period);
  assign xfer      = cfg_valid & ~pending;
  // A disabled block has no boundary to wait for, so pending config lands at once.
  assign apply     = pending & (~enable | at_end);
  assign cfg_ready = ~pending;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shadow_period <= '0;
      shadow_duty   <= '0;
      shadow_inv    <= '0;
      pending       <= 1'b0;
    end else if (xfer) begin
      shadow_period <= cfg_period;
      shadow_duty   <= cfg_duty;
      shadow_inv    <= cfg_inv;
      pending       <= 1'b1;
    end else if (apply) begin
      pending       <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active_period <= RST_P;
      active_duty   <= {NUM_CH{RST_D}};
      active_inv    <= '0;
    end else if (apply) begin
      active_period <= shadow_period;
      active_duty   <= shadow_duty;
      active_inv    <= shadow_inv;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt         <= '0;
      pwm_out     <= '0;
      period_done <= 1'b0;
    end else if (enable) begin
      pwm_out     <= level;
      period_done <= at_end;
      cnt         <= at_end ? '0 : cnt + CNT_W'(1);
    end else begin
      pwm_out     <= active_inv;
      period_done <= 1'b0;
      cnt         <= '0;
    end
  end

endmodule

// File: tb/tb_pwm_multi_channel.sv
// Scoreboard bench for pwm_multi_channel: stimulus pushes the expected
// per-cycle outputs, a monitor pops and compares one entry per clock.
module tb_pwm_multi_channel;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  cfg_period;
  logic [31:0] cfg_duty;
  logic [3:0]  cfg_inv;
  logic [3:0]  pwm_out;
  logic        period_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] pwm;
    logic       pd;
    logic       rdy;
    string      nm;
  } exp_t;

  exp_t exp_q[$];

  localparam logic [31:0] D_RST = 32'h01010101;
  localparam logic [31:0] D_A   = 32'h050A0003;
  localparam logic [31:0] D_B   = 32'h070A0003;
  localparam logic [31:0] D_C   = 32'h02020202;

  pwm_multi_channel #(
    .NUM_CH(4), .CNT_W(8), .RESET_PERIOD(3), .RESET_DUTY(1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_period  (cfg_period),
    .cfg_duty    (cfg_duty),
    .cfg_inv     (cfg_inv),
    .pwm_out     (pwm_out),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_pwm(input int k, input logic [31:0] dv, input logic [3:0] inv);
    logic [3:0] e;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      e[i] = (k < int'(dv[i*8 +: 8])) ^ inv[i];
    end
    return e;
  endfunction

  // Push the expectation for the coming clock edge, then move to the next negedge.
  task automatic cyc(input logic [3:0] pwm, input logic pd, input logic rdy, input string nm);
    exp_t e;
    e.pwm = pwm;
    e.pd  = pd;
    e.rdy = rdy;
    e.nm  = nm;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic period(input int p, input logic [31:0] dv, input logic [3:0] inv,
                        input int k0, input int k1, input logic rdy, input string nm);
    for (int k = k0; k <= k1; k++) begin
      cyc(exp_pwm(k, dv, inv), (k == p), rdy, nm);
    end
  endtask

  task automatic offer(input logic [7:0] p, input logic [31:0] dv, input logic [3:0] inv);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_duty   = dv;
    cfg_inv    = inv;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.nm, ".pwm"}, pwm_out, e.pwm);
        check({e.nm, ".done"}, {3'b0, period_done}, {3'b0, e.pd});
        check({e.nm, ".ready"}, {3'b0, cfg_ready}, {3'b0, e.rdy});
      end
    end
  end

  initial begin : stimulus
    reset_n    = 1'b0;
    enable     = 1'b0;
    cfg_valid  = 1'b0;
    cfg_period = '0;
    cfg_duty   = '0;
    cfg_inv    = '0;
    #1;
    check("rst.pwm", pwm_out, 4'h0);
    check("rst.done", {3'b0, period_done}, 4'h0);
    check("rst.ready", {3'b0, cfg_ready}, 4'h1);

    @(negedge clk);
    reset_n = 1'b1;
    enable  = 1'b1;

    // default pattern 1,0,0,0
    period(3, D_RST, 4'h0, 0, 3, 1'b1, "t1");
    period(3, D_RST, 4'h0, 0, 3, 1'b1, "t1");

    // mid-period config A; a second offer (B) is held while A is pending
    period(3, D_RST, 4'h0, 0, 1, 1'b1, "t2.pre");
    offer(8'd9, D_A, 4'h0);
    cyc(4'h0, 1'b0, 1'b0, "t2.xfer");
    offer(8'd9, D_B, 4'h1);
    cyc(4'h0, 1'b1, 1'b1, "t3.ignored");
    cyc(exp_pwm(0, D_A, 4'h0), 1'b0, 1'b0, "t3.xfer");
    cfg_valid = 1'b0;
    period(9, D_A, 4'h0, 1, 8, 1'b0, "t2.A");
    period(9, D_A, 4'h0, 9, 9, 1'b1, "t2.A_end");
    period(9, D_B, 4'h1, 0, 9, 1'b1, "t4.B");

    // disable: idle at inv, pending config applied without boundary
    period(9, D_B, 4'h1, 0, 2, 1'b1, "t4.B2");
    enable = 1'b0;
    offer(8'd4, D_C, 4'h0);
    cyc(4'h1, 1'b0, 1'b0, "t4.idle_xfer");
    cfg_valid = 1'b0;
    cyc(4'h1, 1'b0, 1'b1, "t4.idle_apply");
    cyc(4'h0, 1'b0, 1'b1, "t4.idle_new");
    enable = 1'b1;
    period(4, D_C, 4'h0, 0, 4, 1'b1, "t4.C");

    // async reset mid-period with a pending config
    cyc(4'hF, 1'b0, 1'b1, "t5.C0");
    offer(8'd1, 32'h01010101, 4'hF);
    cyc(4'hF, 1'b0, 1'b0, "t5.xfer");
    cfg_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t5.async.pwm", pwm_out, 4'h0);
    check("t5.async.done", {3'b0, period_done}, 4'h0);
    check("t5.async.ready", {3'b0, cfg_ready}, 4'h1);
    @(negedge clk);
    reset_n = 1'b1;
    period(3, D_RST, 4'h0, 0, 3, 1'b1, "t5.restart");
    period(3, D_RST, 4'h0, 0, 3, 1'b1, "t5.restart");

    // P=0 with D=1
    offer(8'd0, 32'h01010101, 4'h0);
    cyc(4'hF, 1'b0, 1'b0, "t6.xfer0");
    cfg_valid = 1'b0;
    cyc(4'h0, 1'b0, 1'b0, "t6.k1");
    cyc(4'h0, 1'b0, 1'b0, "t6.k2");
    cyc(4'h0, 1'b1, 1'b1, "t6.k3");
    for (int n = 0; n < 5; n++) cyc(4'hF, 1'b1, 1'b1, "t6.p0");

    // full-scale period and duty
    offer(8'd255, 32'hFFFFFFFF, 4'h0);
    cyc(4'hF, 1'b1, 1'b0, "t6.xfer_at_end");
    cfg_valid = 1'b0;
    cyc(4'hF, 1'b1, 1'b1, "t6.apply");
    period(255, 32'hFFFFFFFF, 4'h0, 0, 255, 1'b1, "t6.max");
    period(255, 32'hFFFFFFFF, 4'h0, 0, 1, 1'b1, "t6.wrap");

    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
